// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU multiplier result path: status flag layout
// and the queue entry format.
package fpu_pkg;

   localparam int RESULT_W = 32;
   localparam int FLAG_W   = 3;
   localparam int FLAG_EXC = 2;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_UNF = 0;
   localparam int ENTRY_W  = RESULT_W + FLAG_W;

   typedef struct packed {
      logic [RESULT_W-1:0] result;
      logic [FLAG_W-1:0]   flags;
   } fpu_entry_t;

   // Gathers the three multiplier status bits into the shared flag layout.
   function automatic logic [FLAG_W-1:0] pack_flags(input logic exc,
                                                    input logic ovf,
                                                    input logic unf);
      logic [FLAG_W-1:0] f;
      f           = {FLAG_W{1'b0}};
      f[FLAG_EXC] = exc;
      f[FLAG_OVF] = ovf;
      f[FLAG_UNF] = unf;
      return f;
   endfunction

endpackage

// File: rtl/fpu_fifo_ram.sv
// Entry storage for the result queue: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fpu_fifo_ram
   import fpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  fpu_entry_t        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output fpu_entry_t        rdata
);

   fpu_entry_t mem_r [DEPTH];

   // Write port: store the pushed entry at the write pointer.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/fpu_mul_result_queue.sv
// First-word-fall-through queue for FPU multiplier results, with sticky
// status accumulation and a saturating count of accepted results.
module fpu_mul_result_queue
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_out,
   input  logic                     in_exception,
   input  logic                     in_overflow,
   input  logic                     in_underflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [2:0]               out_flags,
   output logic [2:0]               sticky_flags,
   input  logic                     flag_clear,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         result_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic [FLAG_W-1:0] sticky_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              push_s;
   logic              pop_s;
   logic [FLAG_W-1:0] in_flags_s;
   logic [LVL_W-1:0]  level_nxt_s;
   logic [FLAG_W-1:0] sticky_nxt_s;
   logic [CNT_W-1:0]  cnt_nxt_s;
   fpu_entry_t        wr_entry_s;
   fpu_entry_t        rd_entry_s;

   // Handshake status comes only from registered occupancy, never from out_ready.
   assign in_ready  = (level_r < LVL_FULL);
   assign out_valid = (level_r != {LVL_W{1'b0}});
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   assign in_flags_s        = pack_flags(in_exception, in_overflow, in_underflow);
   assign wr_entry_s.result = in_out;
   assign wr_entry_s.flags  = in_flags_s;

   fpu_fifo_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (wr_entry_s),
      .raddr (rd_ptr_r),
      .rdata (rd_entry_s)
   );

   assign out_result   = rd_entry_s.result;
   assign out_flags    = rd_entry_s.flags;
   assign sticky_flags = sticky_r;
   assign level        = level_r;
   assign result_cnt   = cnt_r;

   // Occupancy update; a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Sticky flags: a push wins over a same-cycle clear and leaves exactly its flags.
   always_comb begin
      sticky_nxt_s = sticky_r;
      if (push_s) begin
         sticky_nxt_s = (flag_clear ? {FLAG_W{1'b0}} : sticky_r) | in_flags_s;
      end else if (flag_clear) begin
         sticky_nxt_s = {FLAG_W{1'b0}};
      end else begin
         sticky_nxt_s = sticky_r;
      end
   end

   // Accepted-result counter, saturating at all ones.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (push_s && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Control state; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         sticky_r <= {FLAG_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r  <= level_nxt_s;
         sticky_r <= sticky_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_fpu_mul_result_queue.sv
// Self-checking bench for fpu_mul_result_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fpu_mul_result_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_out;
   logic        in_exception, in_overflow, in_underflow;
   logic        out_ready;
   logic        flag_clear;

   logic        in_ready, out_valid;
   logic [31:0] out_result;
   logic [2:0]  out_flags, sticky_flags;
   logic [2:0]  level;
   logic [15:0] result_cnt;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_result;
   logic [2:0]  s_out_flags, s_sticky_flags;
   logic [2:0]  s_level;
   logic [1:0]  s_result_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   logic [34:0] model_q[$];
   logic [2:0]  model_sticky;
   int          model_cnt;

   always #5 clk = ~clk;

   fpu_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_out(in_out), .in_exception(in_exception), .in_overflow(in_overflow),
      .in_underflow(in_underflow), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .sticky_flags(sticky_flags),
      .flag_clear(flag_clear), .level(level), .result_cnt(result_cnt)
   );

   fpu_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_out(in_out), .in_exception(in_exception), .in_overflow(in_overflow),
      .in_underflow(in_underflow), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_result(s_out_result), .out_flags(s_out_flags), .sticky_flags(s_sticky_flags),
      .flag_clear(flag_clear), .level(s_level), .result_cnt(s_result_cnt)
   );

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      model_sticky = 3'b000;
      model_cnt    = 0;
   endtask

   // Reference behaviour for one rising edge, from the pre-edge state.
   task automatic model_step(input logic v, input logic [31:0] d, input logic [2:0] f,
                             input logic ordy, input logic clr);
      bit do_push;
      bit do_pop;
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = ordy && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
         model_q.push_back({d, f});
         model_sticky = (clr ? 3'b000 : model_sticky) | f;
         model_cnt++;
      end else if (clr) begin
         model_sticky = 3'b000;
      end
   endtask

   task automatic compare_all();
      int sz;
      sz = model_q.size();
      check_value("in_ready", in_ready, (sz < DEPTH));
      check_value("out_valid", out_valid, (sz > 0));
      check_value("level", level, sz);
      check_value("sticky_flags", sticky_flags, model_sticky);
      check_value("result_cnt", result_cnt, (model_cnt > 65535) ? 65535 : model_cnt);
      check_value("result_cnt_sat", s_result_cnt, (model_cnt > 3) ? 3 : model_cnt);
      if (sz > 0) begin
         check_value("out_result", out_result, model_q[0][34:3]);
         check_value("out_flags", out_flags, model_q[0][2:0]);
      end
   endtask

   task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] f,
                        input logic ordy, input logic clr);
      in_valid   = v;
      in_out     = d;
      {in_exception, in_overflow, in_underflow} = f;
      out_ready  = ordy;
      flag_clear = clr;
      @(posedge clk);
      model_step(v, d, f, ordy, clr);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0;
      in_valid = 1'b0; in_out = 32'h0; in_exception = 1'b0; in_overflow = 1'b0;
      in_underflow = 1'b0; out_ready = 1'b0; flag_clear = 1'b0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Single push with a waiting consumer, then drain.
      cycle(1'b1, 32'h40C00000, 3'b000, 1'b1, 1'b0);
      check_value("single_result", out_result, 32'h40C00000);
      check_value("single_cnt", result_cnt, 16'd1);
      cycle(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
      check_value("single_drain_level", level, 3'd0);

      // Five pushes into a stalled consumer, then release.
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000 + i, 3'(i), 1'b0, 1'b0);
      check_value("full_in_ready", in_ready, 1'b0);
      check_value("full_level", level, 3'd4);
      held = 32'h1004;
      for (int i = 0; i < 6; i++) cycle((i == 0), held, 3'd4, 1'b1, 1'b0);
      check_value("drain_empty", out_valid, 1'b0);
      cycle(1'b0, 32'h0, 3'b000, 1'b0, 1'b1);

      // Sticky accumulation and clear priority.
      cycle(1'b1, 32'h7F800000, 3'b010, 1'b1, 1'b0);
      cycle(1'b1, 32'h00000000, 3'b001, 1'b1, 1'b0);
      check_value("sticky_011", sticky_flags, 3'b011);
      cycle(1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
      check_value("sticky_clear", sticky_flags, 3'b000);
      cycle(1'b1, 32'h3F800000, 3'b100, 1'b1, 1'b1);
      check_value("sticky_push_wins", sticky_flags, 3'b100);
      cycle(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

      // Full queue: simultaneous push and pop only pops.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA000 + i, 3'b000, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD, 3'b111, 1'b1, 1'b0);
      check_value("full_pushpop_level", level, 3'd3);
      check_value("full_pushpop_ready", in_ready, 1'b1);

      // Asynchronous reset with three entries queued.
      cycle(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_value("rst_out_valid", out_valid, 1'b0);
      check_value("rst_level", level, 3'd0);
      check_value("rst_sticky", sticky_flags, 3'b000);
      check_value("rst_cnt", result_cnt, 16'd0);
      check_value("rst_in_ready", in_ready, 1'b1);
      #1 rst_n = 1'b1;
      cycle(1'b1, 32'h12345678, 3'b010, 1'b0, 1'b0);
      check_value("post_rst_push", level, 3'd1);

      // Random traffic with alternating consumer pressure.
      for (int i = 0; i < 400; i++) begin
         logic ordy;
         ordy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), ordy,
               $urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fpu_mul_result_queue.md
FPU_MUL_RESULT_QUEUE -- requirements
Module: fpu_mul_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter CNT_W, default 16, width of the accepted-result counter.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, multiplier outputs are valid this cycle.
REQ-006 Port in_ready, output, 1, queue can accept an entry this cycle.
REQ-007 Port in_out, input, 32, multiplier result word.
REQ-008 Port in_exception, in_overflow, in_underflow, input, 1 each, multiplier status bits.
REQ-009 Port out_valid, output, 1, head entry is valid.
REQ-010 Port out_ready, input, 1, consumer takes the head entry.
REQ-011 Port out_result, output, 32, head result word.
REQ-012 Port out_flags, output, 3, head status {exception, overflow, underflow}.
REQ-013 Port sticky_flags, output, 3, accumulated status since reset or last clear, same bit order.
REQ-014 Port flag_clear, input, 1, clears sticky_flags.
REQ-015 Port level, output, $clog2(DEPTH)+1, current occupancy.
REQ-016 Port result_cnt, output, CNT_W, saturating count of accepted entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-018 in_ready SHALL equal (level < DEPTH), derived only from registered state, never from out_ready.
REQ-019 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N; no combinational bypass when empty.
REQ-020 Output SHALL be first-word-fall-through: out_result/out_flags present the head entry whenever out_valid=1 and SHALL hold stable while out_valid && !out_ready.
REQ-021 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-022 Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both operations performed.
REQ-023 Full (level==DEPTH): in_ready=0, in_valid ignored, nothing dropped or overwritten; a pop that cycle makes in_ready=1 on the next cycle.
REQ-024 Empty: out_valid=0, out_ready ignored, level never underflows; out_result/out_flags are don't-care.
REQ-025 On push, sticky_flags SHALL become sticky_flags | {in_exception, in_overflow, in_underflow}.
REQ-026 On flag_clear without a push, sticky_flags SHALL become 0 next cycle; with a same-cycle push, it SHALL become exactly the pushed flags (push wins over clear).
REQ-027 result_cnt SHALL increment by 1 on each push and saturate at 2^CNT_W-1; it is unaffected by flag_clear.
REQ-028 The result word SHALL be stored unmodified; the queue performs no arithmetic on it.

Reset
REQ-029 rst_n low SHALL immediately clear pointers, level=0, out_valid=0, sticky_flags=0, result_cnt=0; in_ready=1 while in reset.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.
REQ-031 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Structure
REQ-032 Shared package fpu_pkg SHALL hold FLAG_W=3, flag bit index constants (FLAG_EXC=2, FLAG_OVF=1, FLAG_UNF=0) and the queue entry typedef {result[31:0], flags[2:0]}.
REQ-033 Entry storage SHALL be a single sub-module fpu_fifo_ram (DEPTH x 35-bit, one write port, one asynchronous read port); control logic stays in fpu_mul_result_queue.

Verification
REQ-034 Single push in_out=0x40C00000, flags=000, out_ready=1 -> out_valid high one cycle later with 0x40C00000, level 1->0, result_cnt=1.
REQ-035 Push 5 entries with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th, 5th held off, level=4; release out_ready -> 4 entries out in order, then 5th.
REQ-036 Push 0x7F800000 with overflow=1, then 0x00000000 with underflow=1 -> sticky_flags=011; flag_clear alone -> 000; flag_clear with push of exception=1 -> 100.
REQ-037 Full queue, push and pop in the same cycle -> pop occurs, push ignored, level=3, next cycle in_ready=1.
REQ-038 rst_n pulsed low with level=3 -> out_valid=0, level=0, sticky_flags=0, result_cnt=0 asynchronously, before next clk edge.
REQ-039 CNT_W=2, push 5 entries -> result_cnt reads 3 and stays 3.
